// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR AXI port arbiter.
package ddr_arb_pkg;

  localparam int              ADDR_W     = 28;
  localparam int              DATA_W     = 256;
  localparam int              ID_W       = 4;
  localparam logic [ID_W-1:0] READ_ID    = 4'hF;
  localparam logic [3:0]      BURST_LEN  = 4'd15;
  localparam int              STARVE_MAX = 8;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    AR,
    R
  } arb_state_t;

  typedef logic req_idx_t;

endpackage

// File: rtl/ddr_axi_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; after a burst the pointer moves to the camera not just served.
module rr_arb2
  import ddr_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  req_idx_t   served,
  output logic [1:0] grant
);

  req_idx_t ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~served;
    end
  end

  always_comb begin
    grant = 2'b00;
    if (ptr == 1'b0) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

endmodule

// File: rtl/ddr_axi_arbiter.sv
// Shares the ddr3_32 AXI port between two camera writers and the HDMI reader, one burst at a time.
// Optional protocol checker driving err is built only when ARB_PROTO_CHK_EN is defined.
//
// state | meaning
// IDLE  | sample requests, pick and latch a winner
// AW    | write address phase, hold until awready
// W     | stream 16 beats from the granted camera
// AR    | read address phase, hold until arready
// R     | pass read beats through until rlast
module ddr_axi_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int         ADDR_W     = ddr_arb_pkg::ADDR_W,
  parameter int         DATA_W     = ddr_arb_pkg::DATA_W,
  parameter logic [3:0] BURST_LEN  = ddr_arb_pkg::BURST_LEN,
  parameter int         STARVE_MAX = ddr_arb_pkg::STARVE_MAX
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              wr_req,
  input  logic [1:0][ADDR_W-1:0]  wr_addr,
  input  logic [1:0][DATA_W-1:0]  wr_data,
  output logic [1:0]              wr_ack,
  output logic [1:0]              wr_done,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic                    rd_last,
  output logic                    rd_done,
  output logic [ADDR_W-1:0]       axi_awaddr,
  output logic                    axi_awuser_ap,
  output logic [ID_W-1:0]         axi_awuser_id,
  output logic [3:0]              axi_awlen,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DATA_W-1:0]       axi_wdata,
  output logic [DATA_W/8-1:0]     axi_wstrb,
  input  logic                    axi_wready,
  input  logic [ID_W-1:0]         axi_wusero_id,
  input  logic                    axi_wusero_last,
  output logic [ADDR_W-1:0]       axi_araddr,
  output logic                    axi_aruser_ap,
  output logic [ID_W-1:0]         axi_aruser_id,
  output logic [3:0]              axi_arlen,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [DATA_W-1:0]       axi_rdata,
  input  logic [ID_W-1:0]         axi_rid,
  input  logic                    axi_rlast,
  input  logic                    axi_rvalid,
  output logic                    err
);

  localparam int             SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]  STARVE_LIM = SW'(STARVE_MAX);

  arb_state_t         state, state_nxt;
  logic [ADDR_W-1:0]  addr_q;
  req_idx_t           idx_q;
  logic [3:0]         beat_q;
  logic [SW-1:0]      starve_q;
  logic [1:0]         wr_grant;
  req_idx_t           wr_gidx;
  logic               any_wr, rd_win, w_last, r_end;

  assign any_wr  = |wr_grant;
  assign wr_gidx = wr_grant[1];
  // A read is only refused when writes are waiting and the starvation budget is spent.
  assign rd_win  = rd_req && ((starve_q < STARVE_LIM) || !any_wr);
  assign w_last  = (state == W) && axi_wready && (beat_q == BURST_LEN);
  assign r_end   = (state == R) && axi_rvalid && axi_rlast;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .advance (w_last),
    .served  (idx_q),
    .grant   (wr_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rd_win)      state_nxt = AR;
        else if (any_wr) state_nxt = AW;
      end
      AW:      if (axi_awready) state_nxt = W;
      W:       if (w_last)      state_nxt = IDLE;
      AR:      if (axi_arready) state_nxt = R;
      R:       if (r_end)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      idx_q    <= 1'b0;
      beat_q   <= '0;
      starve_q <= '0;
      wr_done  <= '0;
      rd_done  <= 1'b0;
    end else begin
      wr_done <= '0;
      rd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_win) begin
            addr_q <= rd_addr;
            if (any_wr && (starve_q < STARVE_LIM)) starve_q <= starve_q + 1'b1;
          end else if (any_wr) begin
            addr_q   <= wr_addr[wr_gidx];
            idx_q    <= wr_gidx;
            starve_q <= '0;
          end
        end
        AW: if (axi_awready) beat_q <= '0;
        W: begin
          if (axi_wready) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == BURST_LEN) wr_done[idx_q] <= 1'b1;
          end
        end
        R: if (r_end) rd_done <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    axi_awaddr    = '0;
    axi_awuser_ap = 1'b0;
    axi_awuser_id = '0;
    axi_awlen     = '0;
    axi_awvalid   = 1'b0;
    axi_wdata     = '0;
    axi_wstrb     = '0;
    wr_ack        = '0;
    axi_araddr    = '0;
    axi_aruser_ap = 1'b0;
    axi_aruser_id = '0;
    axi_arlen     = '0;
    axi_arvalid   = 1'b0;
    rd_data       = '0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    case (state)
      AW: begin
        axi_awaddr    = addr_q;
        axi_awuser_id = {3'b000, idx_q};
        axi_awlen     = BURST_LEN;
        axi_awvalid   = 1'b1;
      end
      W: begin
        axi_wdata     = wr_data[idx_q];
        axi_wstrb     = '1;
        wr_ack[idx_q] = axi_wready;
      end
      AR: begin
        axi_araddr    = addr_q;
        axi_aruser_id = READ_ID;
        axi_arlen     = BURST_LEN;
        axi_arvalid   = 1'b1;
      end
      R: begin
        rd_data  = axi_rdata;
        rd_valid = axi_rvalid;
        rd_last  = axi_rlast;
      end
      default: ;
    endcase
  end

`ifdef ARB_PROTO_CHK_EN
  logic err_q, err_set;
  logic unused_chk;

  assign err_set = (axi_rvalid && (state != R))
                || ((state == R) && axi_rvalid && (axi_rid != READ_ID))
                || ((state == W) && axi_wready && axi_wusero_last && (beat_q != BURST_LEN))
                || (axi_wready && (state != W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | err_set;
  end

  assign err        = err_q;
  assign unused_chk = ^axi_wusero_id;
`else
  logic unused_chk;
  assign err        = 1'b0;
  assign unused_chk = ^{axi_wusero_id, axi_rid, axi_wusero_last};
`endif

endmodule
